// File: rtl/vc_crossbar_rr_n_pkg.sv
// Shared constants for the round-robin message crossbar.
//   DOM_NORMAL / DOM_SECURE : encodings of the per-message security domain tag
//   ERR_CNT_W               : width of the saturating violation counter
package vc_crossbar_rr_n_pkg;

  localparam logic DOM_NORMAL = 1'b0;
  localparam logic DOM_SECURE = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/vc_rr_arb_n.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, reset : clock, asynchronous active-low reset
//   req        : per-requester request vector
//   en         : grant is consumed this cycle; pointer advances only when set
//   grant_c    : one-hot combinational grant (zero when no requests)
module vc_rr_arb_n #(
  parameter  int unsigned p_nports = 4,
  localparam int unsigned c_dbits  = $clog2(p_nports)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [p_nports-1:0] req,
  input  logic                en,
  output logic [p_nports-1:0] grant_c
);

  logic [c_dbits-1:0] ptr;
  logic [c_dbits-1:0] winner;
  logic [c_dbits-1:0] idx_d;
  logic [31:0]        idx;
  logic               found;

  // Search from ptr upward, wrapping modulo p_nports; first requester wins.
  always_comb begin
    grant_c = '0;
    winner  = '0;
    found   = 1'b0;
    idx     = '0;
    idx_d   = '0;
    for (int unsigned k = 0; k < p_nports; k++) begin
      idx   = (32'(ptr) + 32'(k)) % 32'(p_nports);
      idx_d = c_dbits'(idx);
      if (!found && req[idx_d]) begin
        found          = 1'b1;
        winner         = idx_d;
        grant_c[idx_d] = 1'b1;
      end
    end
  end

  // Next search starts just past the last accepted grantee.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en && found) begin
      if (winner == c_dbits'(p_nports - 1)) ptr <= '0;
      else                                  ptr <= winner + c_dbits'(1);
    end
  end

endmodule

// File: rtl/vc_crossbar_rr_n.sv
// N x N message crossbar with per-output round-robin arbitration, a one-entry
// registered stage per output, and domain filtering on secure outputs.
//   clk, reset          : clock, asynchronous active-low reset
//   in_msg/in_dest/in_domain/in_val/in_rdy : per-input request channel
//   out_msg/out_domain/out_val/out_rdy     : per-output registered channel
//   err_val/err_src/err_cnt                : domain-violation report
module vc_crossbar_rr_n
  import vc_crossbar_rr_n_pkg::*;
#(
  parameter  int unsigned         p_nports      = 4,
  parameter  int unsigned         p_nbits       = 32,
  parameter  logic [p_nports-1:0] p_secure_mask = '0,
  localparam int unsigned         c_dbits       = $clog2(p_nports)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [p_nports*p_nbits-1:0] in_msg,
  input  logic [p_nports*c_dbits-1:0] in_dest,
  input  logic [p_nports-1:0]         in_domain,
  input  logic [p_nports-1:0]         in_val,
  output logic [p_nports-1:0]         in_rdy,
  output logic [p_nports*p_nbits-1:0] out_msg,
  output logic [p_nports-1:0]         out_domain,
  output logic [p_nports-1:0]         out_val,
  input  logic [p_nports-1:0]         out_rdy,
  output logic                        err_val,
  output logic [c_dbits-1:0]          err_src,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  localparam int unsigned SUM_W = ERR_CNT_W + 1;

  logic [p_nports-1:0]         viol;
  logic [p_nports-1:0]         req   [p_nports];
  logic [p_nports-1:0]         grant [p_nports];
  logic [p_nports-1:0]         can_acc;
  logic [p_nports*p_nbits-1:0] nxt_msg;
  logic [p_nports-1:0]         nxt_dom;
  logic [p_nports-1:0]         nxt_val;
  logic [c_dbits-1:0]          d;
  logic                        in_range;
  logic                        sec_hit;
  logic [c_dbits-1:0]          low_src;
  logic [SUM_W-1:0]            cnt_sum;

  // Classify each input: violation (consumed, dropped) or legal request to
  // its destination. Everything is gated by reset so nothing is granted then.
  always_comb begin
    viol     = '0;
    d        = '0;
    in_range = 1'b0;
    sec_hit  = 1'b0;
    for (int j = 0; j < p_nports; j++) req[j] = '0;
    for (int i = 0; i < p_nports; i++) begin
      d        = in_dest[i*c_dbits +: c_dbits];
      in_range = 1'b0;
      sec_hit  = 1'b0;
      for (int j = 0; j < p_nports; j++) begin
        if (d == c_dbits'(j)) begin
          in_range = 1'b1;
          sec_hit  = p_secure_mask[j];
        end
      end
      viol[i] = reset && in_val[i] &&
                (!in_range || (sec_hit && in_domain[i] == DOM_NORMAL));
      for (int j = 0; j < p_nports; j++) begin
        req[j][i] = reset && in_val[i] && !viol[i] && (d == c_dbits'(j));
      end
    end
  end

  for (genvar j = 0; j < p_nports; j++) begin : g_arb
    assign can_acc[j] = !out_val[j] || out_rdy[j];

    vc_rr_arb_n #(.p_nports(p_nports)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req[j]),
      .en      (can_acc[j]),
      .grant_c (grant[j])
    );
  end

  // Ready/next-state for the output stages; a draining stage can refill in
  // the same cycle.
  always_comb begin
    in_rdy  = viol;
    nxt_msg = out_msg;
    nxt_dom = out_domain;
    nxt_val = out_val;
    for (int j = 0; j < p_nports; j++) begin
      if (out_rdy[j]) nxt_val[j] = 1'b0;
      for (int i = 0; i < p_nports; i++) begin
        if (grant[j][i] && can_acc[j]) begin
          in_rdy[i]                    = 1'b1;
          nxt_val[j]                   = 1'b1;
          nxt_msg[j*p_nbits +: p_nbits] = in_msg[i*p_nbits +: p_nbits];
          nxt_dom[j]                   = in_domain[i];
        end
      end
    end
  end

  // Lowest violating index and saturating count update.
  always_comb begin
    low_src = '0;
    cnt_sum = SUM_W'(err_cnt);
    for (int i = p_nports - 1; i >= 0; i--) begin
      if (viol[i]) low_src = c_dbits'(i);
    end
    for (int i = 0; i < p_nports; i++) begin
      cnt_sum = cnt_sum + SUM_W'(viol[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_msg    <= '0;
      out_domain <= '0;
      out_val    <= '0;
      err_val    <= 1'b0;
      err_src    <= '0;
      err_cnt    <= '0;
    end else begin
      out_msg    <= nxt_msg;
      out_domain <= nxt_dom;
      out_val    <= nxt_val;
      err_val    <= |viol;
      if (|viol) err_src <= low_src;
      if (cnt_sum > SUM_W'({ERR_CNT_W{1'b1}})) err_cnt <= {ERR_CNT_W{1'b1}};
      else                                     err_cnt <= cnt_sum[ERR_CNT_W-1:0];
    end
  end

endmodule
